// File: rtl/latch_bank_wr_ctrl_pkg.sv
// Shared types and helpers for the latch-bank write controller.
package latch_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int ONEHOT_MAX = 256;

  // Counter must hold max(S,P,H)-1; the +1 keeps a width of at least one bit.
  function automatic int cnt_w(input int s, input int p, input int h);
    int m;
    m = (s > p) ? s : p;
    m = (m > h) ? m : h;
    return $clog2(m) + 1;
  endfunction

  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [31:0] idx);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    if (idx < ONEHOT_MAX) v[idx[7:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/latch_bank_wr_ctrl_if.sv
// Write handshake plus latch-bank drive bus.
interface latch_bank_wr_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
);
  logic             WR_VALID;
  logic             WR_READY;
  logic [AW-1:0]    WR_ADDR;
  logic [WIDTH-1:0] WR_DATA;
  logic [WIDTH-1:0] LD_D;
  logic [DEPTH-1:0] LD_G;
  logic             BUSY;
  logic             ADDR_ERR;

  modport master (
    output WR_VALID, WR_ADDR, WR_DATA,
    input  WR_READY, LD_D, LD_G, BUSY, ADDR_ERR
  );

  modport slave (
    input  WR_VALID, WR_ADDR, WR_DATA,
    output WR_READY, LD_D, LD_G, BUSY, ADDR_ERR
  );
endinterface

// File: rtl/latch_bank_wr_ctrl_phase_timer.sv
// Loadable down-counter timing the SETUP/PULSE/HOLD phases.
module phase_timer #(
  parameter int CW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)              r_cnt <= '0;
    else if (i_load)        r_cnt <= i_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Write controller for a GTECH_LD1 latch bank: registered D bus, one timed
// one-hot gate pulse per write with D-stable setup and hold around it.
module latch_bank_wr_ctrl
  import latch_wr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input logic                 CP,
  input logic                 RST,
  latch_bank_wr_ctrl_if.slave wr
);
  localparam int CW = cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SETUP = SETUP;
  localparam logic [1:0] ST_PULSE = PULSE;
  localparam logic [1:0] ST_HOLD  = HOLD;

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
    $fatal(1, "latch_bank_wr_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must be >= 1");
  end
  if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_depth
    $fatal(1, "latch_bank_wr_ctrl: DEPTH must be in 1..2**AW");
  end

  logic [1:0]       r_state;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_ld_d;
  logic [DEPTH-1:0] r_ld_g;
  logic             r_addr_err;

  logic             w_accept;
  logic             w_addr_oob;
  logic             w_load;
  logic [CW-1:0]    w_load_val;
  logic [CW-1:0]    w_cnt;
  logic             w_zero;

  assign w_accept   = (r_state == ST_IDLE) && wr.WR_VALID;
  assign w_addr_oob = {1'b0, wr.WR_ADDR} >= (AW+1)'(DEPTH);

  // Each phase loads N-1 on entry and leaves on the cycle the count hits zero.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE:  if (w_accept) begin w_load = 1'b1; w_load_val = CW'(SETUP_CYC - 1); end
      ST_SETUP: if (w_zero)   begin w_load = 1'b1; w_load_val = CW'(PULSE_CYC - 1); end
      ST_PULSE: if (w_zero)   begin w_load = 1'b1; w_load_val = CW'(HOLD_CYC - 1);  end
      default: ;
    endcase
    assert (RST || (w_zero == (w_cnt == '0)));
  end

  phase_timer #(.CW(CW)) u_timer (
    .i_clk  (CP),
    .i_rst  (RST),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );

  // Gate and data are written in different states, so they never move on the same edge.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_ld_d     <= '0;
      r_ld_g     <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_ld_d     <= wr.WR_DATA;
          r_addr     <= wr.WR_ADDR;
          r_addr_err <= w_addr_oob;
          r_state    <= ST_SETUP;
        end
        ST_SETUP: if (w_zero) begin
          r_ld_g  <= DEPTH'(onehot(32'(r_addr)));
          r_state <= ST_PULSE;
        end
        ST_PULSE: if (w_zero) begin
          r_ld_g  <= '0;
          r_state <= ST_HOLD;
        end
        default: if (w_zero) r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr.LD_D     = r_ld_d;
  assign wr.LD_G     = r_ld_g;
  assign wr.WR_READY = (r_state == ST_IDLE);
  assign wr.BUSY     = (r_state != ST_IDLE);
  assign wr.ADDR_ERR = r_addr_err;
endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Three controller configurations driven with identical stimulus, each checked
// every cycle against a timeline model built from the accept time.
module tb_latch_bank_wr_ctrl;
  logic CP = 1'b0;
  logic RST = 1'b1;
  always #5 CP = ~CP;

  logic       valid = 1'b0;
  logic [1:0] addr  = '0;
  logic [7:0] data  = '0;

  latch_bank_wr_ctrl_if #(.WIDTH(8), .DEPTH(4), .AW(2)) if0 ();
  latch_bank_wr_ctrl_if #(.WIDTH(8), .DEPTH(4), .AW(2)) if1 ();
  latch_bank_wr_ctrl_if #(.WIDTH(8), .DEPTH(3), .AW(2)) if2 ();

  assign if0.WR_VALID = valid; assign if0.WR_ADDR = addr; assign if0.WR_DATA = data;
  assign if1.WR_VALID = valid; assign if1.WR_ADDR = addr; assign if1.WR_DATA = data;
  assign if2.WR_VALID = valid; assign if2.WR_ADDR = addr; assign if2.WR_DATA = data;

  latch_bank_wr_ctrl #(.WIDTH(8), .DEPTH(4), .AW(2), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1))
    u0 (.CP(CP), .RST(RST), .wr(if0.slave));
  latch_bank_wr_ctrl #(.WIDTH(8), .DEPTH(4), .AW(2), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2))
    u1 (.CP(CP), .RST(RST), .wr(if1.slave));
  latch_bank_wr_ctrl #(.WIDTH(8), .DEPTH(3), .AW(2), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1))
    u2 (.CP(CP), .RST(RST), .wr(if2.slave));

  logic [7:0] g_d   [3];
  logic [3:0] g_g   [3];
  logic       g_rdy [3];
  logic       g_busy[3];
  logic       g_err [3];
  assign g_d[0] = if0.LD_D; assign g_g[0] = if0.LD_G;         assign g_rdy[0] = if0.WR_READY;
  assign g_d[1] = if1.LD_D; assign g_g[1] = if1.LD_G;         assign g_rdy[1] = if1.WR_READY;
  assign g_d[2] = if2.LD_D; assign g_g[2] = {1'b0, if2.LD_G}; assign g_rdy[2] = if2.WR_READY;
  assign g_busy[0] = if0.BUSY; assign g_err[0] = if0.ADDR_ERR;
  assign g_busy[1] = if1.BUSY; assign g_err[1] = if1.ADDR_ERR;
  assign g_busy[2] = if2.BUSY; assign g_err[2] = if2.ADDR_ERR;

  // per-configuration timing and depth
  int S_[3] = '{1, 2, 1};
  int P_[3] = '{1, 3, 1};
  int H_[3] = '{1, 2, 1};
  int D_[3] = '{4, 4, 3};

  // model: most recent accepted write and the edge number it was accepted on
  bit         have [3];
  int         t0   [3];
  int         maddr[3];
  logic [7:0] mdata[3];
  logic [7:0] prev_d[3];
  logic [3:0] prev_g[3];

  int errs = 0;
  int checks = 0;

  int ecnt;
  always @(posedge CP or posedge RST) begin
    if (RST) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s[%0d] edge=%0d got=%0h exp=%0h", tag, k, ecnt, got, exp);
    end
  endtask

  function automatic bit active(input int k);
    return have[k] && ecnt >= t0[k] && ecnt < t0[k] + S_[k] + P_[k] + H_[k];
  endfunction

  function automatic logic [3:0] exp_g(input int k);
    if (active(k) && ecnt >= t0[k] + S_[k] && ecnt < t0[k] + S_[k] + P_[k] && maddr[k] < D_[k])
      return 4'(1 << maddr[k]);
    return 4'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      have[k] = 1'b0; t0[k] = 0; maddr[k] = 0; mdata[k] = 8'h00;
      prev_d[k] = 8'h00; prev_g[k] = 4'h0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("ld_d",  k, 32'(g_d[k]),    32'(mdata[k]));
      chk("ld_g",  k, 32'(g_g[k]),    32'(exp_g(k)));
      chk("ready", k, 32'(g_rdy[k]),  32'(!active(k)));
      chk("busy",  k, 32'(g_busy[k]), 32'(active(k)));
      chk("aerr",  k, 32'(g_err[k]),  32'(have[k] && ecnt == t0[k] && maddr[k] >= D_[k]));
      chk("g_d_same_edge", k, 32'((g_d[k] != prev_d[k]) && (g_g[k] != prev_g[k])), 32'(0));
      prev_d[k] = g_d[k];
      prev_g[k] = g_g[k];
    end
  endtask

  // check the state after the last edge, then drive inputs for the next one
  task automatic cyc(input bit v, input logic [1:0] a, input logic [7:0] dt);
    @(negedge CP);
    check_all();
    valid = v; addr = a; data = dt;
    for (int k = 0; k < 3; k++)
      if (v && !active(k)) begin
        have[k] = 1'b1; t0[k] = ecnt + 1; maddr[k] = a; mdata[k] = dt;
      end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CP);
    check_all();
    RST = 1'b0;
    repeat (5) cyc(1'b0, 2'd0, 8'h00);

    // single write, then idle long enough for the slowest configuration
    cyc(1'b1, 2'd2, 8'hA5);
    repeat (9) cyc(1'b0, 2'd1, 8'hFF);
    cyc(1'b1, 2'd0, 8'h3C);
    repeat (9) cyc(1'b0, 2'd3, 8'h00);

    // valid held high; payload changes every 4 cycles
    for (int i = 1; i <= 3; i++)
      repeat (4) cyc(1'b1, 2'(i), 8'(8'h11 * i));
    repeat (9) cyc(1'b0, 2'd0, 8'h00);

    // reset in the middle of the default configuration's gate pulse
    cyc(1'b1, 2'd1, 8'h5A);
    cyc(1'b0, 2'd0, 8'h00);
    @(negedge CP);
    chk("pulse_before_rst", 0, 32'(g_g[0]), 32'(4'b0010));
    RST = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_async_g",   k, 32'(g_g[k]),   32'(0));
      chk("rst_async_rdy", k, 32'(g_rdy[k]), 32'(1));
    end
    model_reset();
    @(negedge CP);
    RST = 1'b0;
    repeat (3) cyc(1'b0, 2'd0, 8'h00);

    repeat (400)
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
    repeat (9) cyc(1'b0, 2'd0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
